// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store/load side plus the data RAM write port.
// master = pipeline/RAM environment, slave = store buffer.
interface store_buffer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              st_valid_i;
  logic [1:0]        st_access_i;
  logic [ADDR_W-1:0] st_addr_i;
  logic [31:0]       st_data_i;
  logic              st_ready_o;
  logic              ld_check_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic              ld_conflict_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_ready_i;
  logic              empty_o;
  logic              misalign_o;

  modport master (
    output st_valid_i, st_access_i, st_addr_i, st_data_i, ld_check_i, ld_addr_i, mem_ready_i,
    input  st_ready_o, ld_conflict_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
           empty_o, misalign_o
  );

  modport slave (
    input  st_valid_i, st_access_i, st_addr_i, st_data_i, ld_check_i, ld_addr_i, mem_ready_i,
    output st_ready_o, ld_conflict_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
           empty_o, misalign_o
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: aligns sb/sh/sw into byte-lane word writes,
// queues them, drains one per cycle to the data RAM and flags load hazards.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  store_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic              ent_valid [DEPTH];
  logic [3:0]        ent_be    [DEPTH];
  logic [ADDR_W-1:0] ent_addr  [DEPTH];
  logic [31:0]       ent_data  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              misalign_q;

  logic [3:0]        al_be;
  logic [31:0]       al_data;
  logic              al_mis;
  logic              accept, push, pop, not_empty;
  logic [ADDR_W-1:0] ld_word;
  logic              ld_hit;

  assign not_empty = (count != '0);
  assign accept    = bus.st_valid_i & bus.st_ready_o;
  assign push      = accept & ~al_mis;
  assign pop       = not_empty & bus.mem_ready_i;

  // Byte-lane alignment and misalignment detection of the incoming store
  always_comb begin
    al_be   = '0;
    al_data = '0;
    al_mis  = 1'b0;
    unique case (bus.st_access_i)
      2'b01: begin
        al_be   = 4'b0001 << bus.st_addr_i[1:0];
        al_data = {4{bus.st_data_i[7:0]}};
      end
      2'b10: begin
        al_be   = bus.st_addr_i[1] ? 4'b1100 : 4'b0011;
        al_data = {2{bus.st_data_i[15:0]}};
        al_mis  = bus.st_addr_i[0];
      end
      default: begin
        al_be   = 4'b1111;
        al_data = bus.st_data_i;
        al_mis  = |bus.st_addr_i[1:0];
      end
    endcase
  end

  // Entry storage, pointers, occupancy count and misalign pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_be[i]    <= '0;
        ent_addr[i]  <= '0;
        ent_data[i]  <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      misalign_q <= 1'b0;
    end else begin
      // push and pop never target the same slot: push needs count<DEPTH, pop count>0,
      // so equal pointers imply only one of them can fire
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_be[wr_ptr]    <= al_be;
        ent_addr[wr_ptr]  <= {bus.st_addr_i[ADDR_W-1:2], 2'b00};
        ent_data[wr_ptr]  <= al_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      misalign_q <= accept & al_mis;
    end
  end

  // Load hazard: word-address match against any pending entry
  always_comb begin
    ld_word = bus.ld_addr_i & ~ADDR_W'(3);
    ld_hit  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == ld_word)) ld_hit = 1'b1;
    end
  end

  assign bus.ld_conflict_o = bus.ld_check_i & ld_hit;
  assign bus.st_ready_o    = (count != CNT_FULL);
  assign bus.empty_o       = ~not_empty;
  assign bus.misalign_o    = misalign_q;
  assign bus.mem_we_o      = not_empty;
  assign bus.mem_be_o      = not_empty ? ent_be[rd_ptr]   : '0;
  assign bus.mem_addr_o    = not_empty ? ent_addr[rd_ptr] : '0;
  assign bus.mem_wdata_o   = not_empty ? ent_data[rd_ptr] : '0;
endmodule
